fifo_rd_streamer: RTL and testbench

FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

---
 rtl/fifo_pkg.sv | 12 +
 rtl/stream_skid_buf.sv | 52 +++++
 rtl/fifo_rd_streamer.sv | 94 +++++++++
 tb/tb_fifo_rd_streamer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read streamer: FSM encoding and packet counter width.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer; entry 0 is always the head presented downstream.
module stream_skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_e0;
  logic [WIDTH-1:0] r_e1;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  // Guard against pushing into a full buffer or popping an empty one.
  assign w_push = i_push & (r_cnt != 2'd2);
  assign w_pop  = i_pop  & (r_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy is 1 here, so the new word becomes the head.
          r_e0 <= i_data;
        end
        default: ;
      endcase
    end
  end

  assign o_data = r_e0;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Reads a FIFO and emits fixed-length packets on a valid/ready stream; never truncates a packet when en drops.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic [1:0]           dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; out_data/out_last hold while valid waits for ready.

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_rd_idx;
  logic [PKT_CNT_W-1:0] r_pkt_count;
  logic [1:0]           w_cnt;
  logic [WIDTH:0]       w_head;
  logic                 w_rd_allowed;
  logic                 w_rd;
  logic                 w_pop;
  logic                 w_last_in;

  // Reading depends only on state, occupancy and FIFO flag, never on out_ready.
  assign w_rd_allowed = (r_state == ST_RUN) | ((r_state == ST_STOP) & (r_rd_idx != '0));
  assign w_rd         = w_rd_allowed & ~fifo_empty & (w_cnt < 2'd2);
  assign w_last_in    = (r_rd_idx == LAST_IDX);
  assign w_pop        = out_valid & out_ready;

  stream_skid_buf #(
    .WIDTH(WIDTH + 1)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_rd),
    .i_data ({w_last_in, fifo_data}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_cnt  (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rd_idx    <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd) begin
        if (w_last_in) r_rd_idx <= '0;
        else           r_rd_idx <= r_rd_idx + IDX_W'(1);
      end
      if (w_pop & w_head[WIDTH]) r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_RUN;
      ST_RUN:  if (!en) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (en)                                     w_state_nxt = ST_RUN;
        else if ((r_rd_idx == '0) && (w_cnt == 2'd0)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fifo_rd_en = w_rd;
  assign out_valid  = (w_cnt != 2'd0);
  assign out_data   = w_head[WIDTH-1:0];
  assign out_last   = out_valid & w_head[WIDTH];
  assign busy       = (r_state != ST_IDLE) | (w_cnt != 2'd0);
  assign pkt_count  = r_pkt_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: FIFO model, stream scoreboard and immediate-assertion checks.
module tb_fifo_rd_streamer;
  import fifo_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, fifo_empty, fifo_rd_en, out_valid, out_ready, out_last, busy;
  logic [W-1:0]  fifo_data, out_data;
  logic [15:0]   pkt_count;
  logic [1:0]    dbg_state;

  logic          en1, fifo_empty1, fifo_rd_en1, out_valid1, out_ready1, out_last1, busy1;
  logic [W-1:0]  fifo_data1, out_data1;
  logic [15:0]   pkt_count1;
  logic [1:0]    dbg_state1;

  fifo_rd_streamer #(.WIDTH(W), .PKT_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .pkt_count(pkt_count),
    .dbg_state(dbg_state)
  );

  fifo_rd_streamer #(.WIDTH(W), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .fifo_rd_en(fifo_rd_en1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .busy(busy1), .pkt_count(pkt_count1),
    .dbg_state(dbg_state1)
  );

  // FIFO models and scoreboard
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] f1_q[$];
  logic [W:0]   got_q[$];
  logic [W:0]   got1_q[$];
  logic [W:0]   exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int rd_count = 0;
  int rd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_data   = fifo_empty ? '0 : fifo_q[0];
    fifo_empty1 = (f1_q.size() == 0);
    fifo_data1  = fifo_empty1 ? '0 : f1_q[0];
  endtask

  // driver: one clock; observations at negedge, model update after the posedge
  task automatic cycle();
    logic rd, beat, rd1, beat1;
    logic [W:0] b, b1;
    @(negedge clk);
    rd    = fifo_rd_en & ~fifo_empty;
    beat  = out_valid & out_ready;
    b     = {out_last, out_data};
    rd1   = fifo_rd_en1 & ~fifo_empty1;
    beat1 = out_valid1 & out_ready1;
    b1    = {out_last1, out_data1};
    @(posedge clk);
    #1;
    if (rd) begin fifo_q.delete(0); rd_count++; end
    if (beat) got_q.push_back(b);
    if (rd1) f1_q.delete(0);
    if (beat1) got1_q.push_back(b1);
    drive_fifo();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_got(input int n, input int max_cyc, input string tag);
    int k;
    k = 0;
    while ((got_q.size() < n) && (k < max_cyc)) begin
      cycle();
      k++;
    end
    chk({tag, "_timeout"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic add_exp(input logic [W-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    en1 = 1'b0; out_ready1 = 1'b0;
    drive_fifo();
    cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_last",  32'(out_last), 32'd0);
    chk("rst_data",  32'(out_data), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_pkt",   32'(pkt_count), 32'd0);

    // 8 words, two packets, continuous ready; PKT_LEN=1 instance alongside
    for (int i = 1; i <= 8; i++) begin
      fifo_q.push_back(W'(i));
      add_exp(W'(i), (i == 4) || (i == 8));
    end
    for (int i = 0; i < 3; i++) f1_q.push_back(W'(8'hA0 + i));
    drive_fifo();
    en = 1'b1; out_ready = 1'b1; en1 = 1'b1; out_ready1 = 1'b1;
    run(9);
    chk("s1_beats_at9", 32'(got_q.size()), 32'd7);
    run(1);
    chk("s1_beats_at10", 32'(got_q.size()), 32'd8);
    check_stream("s1");
    chk("s1_pkt", 32'(pkt_count), 32'd2);
    chk("p1_len", 32'(got1_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got1_q.size()) chk("p1_beat", 32'(got1_q[i]), 32'({1'b1, W'(8'hA0 + i)}));
    chk("p1_pkt", 32'(pkt_count1), 32'd3);

    // downstream stall for 10 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(W'(8'h10 + i));
      add_exp(W'(8'h10 + i), (i == 3) || (i == 7));
    end
    drive_fifo();
    rd0 = rd_count;
    run(10);
    chk("s2_reads", 32'(rd_count - rd0), 32'd2);
    chk("s2_valid", 32'(out_valid), 32'd1);
    chk("s2_hold",  32'(out_data), 32'h10);
    chk("s2_last",  32'(out_last), 32'd0);
    out_ready = 1'b1;
    wait_got(8, 40, "s2");
    check_stream("s2");
    chk("s2_pkt", 32'(pkt_count), 32'd4);

    // en drops after 2 beats; packet completes through STOP, then IDLE
    fifo_q.push_back(8'h20); fifo_q.push_back(8'h21);
    drive_fifo();
    rd0 = rd_count;
    wait_got(2, 20, "s3a");
    en = 1'b0;
    for (int i = 2; i < 6; i++) fifo_q.push_back(W'(8'h20 + i));
    drive_fifo();
    for (int i = 0; i < 4; i++) add_exp(W'(8'h20 + i), i == 3);
    wait_got(4, 20, "s3b");
    run(4);
    check_stream("s3");
    chk("s3_reads", 32'(rd_count - rd0), 32'd4);
    chk("s3_left", 32'(fifo_q.size()), 32'd2);
    chk("s3_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("s3_busy", 32'(busy), 32'd0);
    chk("s3_pkt", 32'(pkt_count), 32'd5);

    // FIFO runs dry after beat 2, refills later
    en = 1'b1;
    add_exp(8'h24, 1'b0); add_exp(8'h25, 1'b0);
    run(8);
    chk("s4_gap_beats", 32'(got_q.size()), 32'd2);
    chk("s4_gap_valid", 32'(out_valid), 32'd0);
    chk("s4_gap_busy",  32'(busy), 32'd1);
    fifo_q.push_back(8'h26); fifo_q.push_back(8'h27);
    drive_fifo();
    add_exp(8'h26, 1'b0); add_exp(8'h27, 1'b1);
    wait_got(4, 20, "s4");
    check_stream("s4");
    chk("s4_pkt", 32'(pkt_count), 32'd6);

    // build cnt=2, rd_idx=3, then reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(W'(8'h30 + i));
    drive_fifo();
    rd0 = rd_count;
    run(4);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("s5_reads", 32'(rd_count - rd0), 32'd3);
    chk("s5_head", 32'(out_data), 32'h31);
    rst = 1'b1; en = 1'b0;
    cycle();
    rst = 1'b0;
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_pkt",   32'(pkt_count), 32'd0);
    chk("s5_busy",  32'(busy), 32'd0);
    chk("s5_data",  32'(out_data), 32'd0);
    got_q.delete();
    exp_q.delete();
    fifo_q.delete();
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(W'(8'h50 + i));
      add_exp(W'(8'h50 + i), i == 3);
    end
    drive_fifo();
    en = 1'b1; out_ready = 1'b1;
    wait_got(4, 20, "s5");
    check_stream("s5");
    chk("s5_pkt_after", 32'(pkt_count), 32'd1);

    // 1000 words with random ready
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    got_q.delete();
    for (int i = 0; i < 1000; i++) begin
      fifo_q.push_back(W'(i));
      add_exp(W'(i), (i % 4) == 3);
    end
    drive_fifo();
    begin
      int k;
      k = 0;
      while ((got_q.size() < 1000) && (k < 6000)) begin
        out_ready = 1'($urandom_range(0, 1));
        cycle();
        k++;
      end
    end
    out_ready = 1'b1;
    check_stream("s6");
    chk("s6_pkt", 32'(pkt_count), 32'd250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
